// File: rtl/delta_sigma_decimator.sv
// Sinc3 CIC decimator: turns a unipolar 1-bit delta-sigma stream into
// left-justified unsigned PCM samples delivered on a valid/ready port.
module delta_sigma_decimator #(
    parameter int DATA_SIZE  = 32,
    parameter int DECIM_LOG2 = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bitIn,
    input  logic                 bitEn,
    output logic [DATA_SIZE-1:0] dataOut,
    output logic                 dataValid,
    input  logic                 dataReady,
    output logic                 overrun
);

    localparam int RAW_W = 3 * DECIM_LOG2;
    localparam int W     = RAW_W + 1;
    localparam int SHIFT = DATA_SIZE - RAW_W;

    logic [W-1:0]          integ1;
    logic [W-1:0]          integ2;
    logic [W-1:0]          integ3;
    logic [W-1:0]          integ1Next;
    logic [W-1:0]          integ2Next;
    logic [W-1:0]          integ3Next;
    logic [DECIM_LOG2-1:0] decimCount;
    logic                  decimPoint;
    logic [W-1:0]          decimSample;
    logic                  combPending;
    logic [W-1:0]          combDelay1;
    logic [W-1:0]          combDelay2;
    logic [W-1:0]          combDelay3;
    logic [W-1:0]          comb1;
    logic [W-1:0]          comb2;
    logic [W-1:0]          comb3;
    logic [1:0]            warmCount;
    logic                  newSample;
    logic [RAW_W-1:0]      rawSat;
    logic [DATA_SIZE-1:0]  scaled;

    // Integrators wrap modulo 2**W on purpose; the comb differences cancel it.
    always_comb begin
        integ1Next = integ1 + W'(bitIn);
        integ2Next = integ2 + integ1Next;
        integ3Next = integ3 + integ2Next;
    end

    assign decimPoint = bitEn && (decimCount == '1);

    always_comb begin
        comb1  = decimSample - combDelay1;
        comb2  = comb1 - combDelay2;
        comb3  = comb2 - combDelay3;
        // Only an all-ones stream reaches R**3, which needs the extra bit.
        rawSat = comb3[RAW_W] ? '1 : comb3[RAW_W-1:0];
        scaled = DATA_SIZE'(rawSat) << SHIFT;
    end

    // The first two comb results only prime the comb delays.
    assign newSample = combPending && (warmCount == 2'd2);

    // Output handshake: a sample transfers on any clock edge where dataValid
    // and dataReady are both high. dataOut holds while dataValid is high
    // unless a new sample loads; loading over an unaccepted sample sets the
    // sticky overrun flag, loading in the same cycle as a transfer does not.
    always_ff @(posedge clk) begin
        if (!reset) begin
            integ1      <= '0;
            integ2      <= '0;
            integ3      <= '0;
            decimCount  <= '0;
            decimSample <= '0;
            combPending <= 1'b0;
            combDelay1  <= '0;
            combDelay2  <= '0;
            combDelay3  <= '0;
            warmCount   <= '0;
            dataOut     <= '0;
            dataValid   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (bitEn) begin
                integ1     <= integ1Next;
                integ2     <= integ2Next;
                integ3     <= integ3Next;
                decimCount <= decimCount + 1'b1;
            end

            if (decimPoint) begin
                decimSample <= integ3Next;
            end
            combPending <= decimPoint;

            if (combPending) begin
                combDelay1 <= decimSample;
                combDelay2 <= comb1;
                combDelay3 <= comb2;
                if (warmCount != 2'd2) begin
                    warmCount <= warmCount + 2'd1;
                end
            end

            if (newSample) begin
                dataOut   <= scaled;
                dataValid <= 1'b1;
                if (dataValid && !dataReady) begin
                    overrun <= 1'b1;
                end
            end else if (dataValid && dataReady) begin
                dataValid <= 1'b0;
            end
        end
    end

endmodule
